// File: rtl/hilf_pkg.sv
// Shared types and constants for the ISI shaping loop-filter sequencer.
package hilf_pkg;

    localparam int NUM_EL    = 6;
    localparam int SFI_W     = 4;
    localparam int SFI_BUS_W = NUM_EL * SFI_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } hilf_state_e;

    function automatic logic [SFI_W-1:0] sfi_nibble(input logic [SFI_BUS_W-1:0] bus,
                                                    input int idx);
        return bus[idx*SFI_W +: SFI_W];
    endfunction

endpackage

// File: rtl/hilf_seq_ctrl_if.sv
// Encoder-to-sequencer vector handshake.
// A vector transfers on every cycle where st_valid and st_ready are both high;
// st_ready is only raised on an update tick and does not wait on st_valid.
interface hilf_seq_ctrl_if;
    import hilf_pkg::*;

    logic [NUM_EL-1:0] st_in;
    logic              st_valid;
    logic              st_ready;

    modport master (output st_in, output st_valid, input st_ready);
    modport slave  (input st_in, input st_valid, output st_ready);
endinterface

// File: rtl/hilf_tick_gen.sv
// Update-rate divider: period is div_q+1 cycles, reloaded from div_cfg on load.
module hilf_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_q <= div_cfg;
            cnt   <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

    assign tick = en && (cnt == div_q);

endmodule

// File: rtl/hilf_seq_ctrl.sv
// Run-time sequencer for the 6-element ISI shaping loop filter: clear, paced
// vector updates, zero-vector drain on stop, and sticky underrun/overflow flags.
module hilf_seq_ctrl
    import hilf_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int OVF_TH    = 12,
    parameter int FLUSH_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_W-1:0]     div_cfg,
    hilf_seq_ctrl_if.slave       st,
    output logic [NUM_EL-1:0]    st_out,
    output logic                 filt_en,
    output logic                 filt_clr,
    input  logic [SFI_BUS_W-1:0] sfi_bus,
    output logic                 busy,
    output logic                 underrun,
    output logic                 ovf_alarm,
    output hilf_state_e          state_dbg
);

    localparam int FCNT_W = $clog2(FLUSH_CYC + 1);

    hilf_state_e       state, state_nxt;
    logic              tick;
    logic              stop_lat;
    logic [FCNT_W-1:0] fcnt;
    logic              sfi_zero, sfi_ovf;
    logic              accept, flush_done, flush_pulse;

    hilf_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .load    (state == CLEAR),
        .en      ((state == RUN) || (state == FLUSH)),
        .div_cfg (div_cfg),
        .tick    (tick)
    );

    always_comb begin
        sfi_zero = 1'b1;
        sfi_ovf  = 1'b0;
        for (int i = 0; i < NUM_EL; i++) begin
            if (sfi_nibble(sfi_bus, i) != '0)             sfi_zero = 1'b0;
            if (sfi_nibble(sfi_bus, i) >= SFI_W'(OVF_TH)) sfi_ovf  = 1'b1;
        end
    end

    // A latched stop consumes the tick instead of accepting a vector.
    assign accept      = (state == RUN) && tick && !stop_lat;
    assign flush_done  = sfi_zero || (fcnt == FCNT_W'(FLUSH_CYC));
    assign flush_pulse = (state == FLUSH) && tick && !flush_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = CLEAR;
            CLEAR:                           state_nxt = RUN;
            RUN:     if (tick && stop_lat)   state_nxt = FLUSH;
            FLUSH:   if (tick && flush_done) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        filt_clr  = (state == CLEAR);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    assign st.st_ready = accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_out    <= '0;
            filt_en   <= 1'b0;
            fcnt      <= '0;
            stop_lat  <= 1'b0;
            underrun  <= 1'b0;
            ovf_alarm <= 1'b0;
        end else begin
            filt_en <= accept || flush_pulse;

            if (accept)                            st_out <= st.st_valid ? st.st_in : '0;
            else if (flush_pulse || state == IDLE) st_out <= '0;

            if (state == CLEAR)   fcnt <= '0;
            else if (flush_pulse) fcnt <= fcnt + FCNT_W'(1);

            if (state == IDLE)                                  stop_lat <= 1'b0;
            else if ((state == CLEAR || state == RUN) && stop) stop_lat <= 1'b1;

            if (state == IDLE && start)       underrun <= 1'b0;
            else if (accept && !st.st_valid) underrun <= 1'b1;

            // The filter outputs are judged on the cycle they are being clocked.
            if (state == IDLE && start) ovf_alarm <= 1'b0;
            else if (filt_en && sfi_ovf) ovf_alarm <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hilf_seq_ctrl.sv
// Directed-plus-random bench for hilf_seq_ctrl against a cycle-count reference model.
module tb_hilf_seq_ctrl;
  import hilf_pkg::*;

  localparam int TB_DIV_W  = 8;
  localparam int TB_OVF_TH = 12;
  localparam int TB_FLUSH  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start, stop;
  logic [TB_DIV_W-1:0]  div_cfg;
  logic [5:0]           st_out;
  logic                 filt_en, filt_clr;
  logic [23:0]          sfi_bus;
  logic                 busy, underrun, ovf_alarm;
  hilf_state_e          state_dbg;

  hilf_seq_ctrl_if st_if ();

  hilf_seq_ctrl #(.DIV_W(TB_DIV_W), .OVF_TH(TB_OVF_TH), .FLUSH_CYC(TB_FLUSH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .div_cfg   (div_cfg),
    .st        (st_if.slave),
    .st_out    (st_out),
    .filt_en   (filt_en),
    .filt_clr  (filt_clr),
    .sfi_bus   (sfi_bus),
    .busy      (busy),
    .underrun  (underrun),
    .ovf_alarm (ovf_alarm),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: phase 0 idle, 1 clear, 2 run, 3 drain; m_c counts cycles since start
  int         ph, m_c, m_d, m_f;
  bit         m_en, m_stop, m_under, m_alarm;
  logic [5:0] m_last;
  logic [5:0] exp_q[$];
  int         sfi_mode;
  logic [23:0] sfi_val;
  int         en_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit m_tick();
    return (ph == 2 || ph == 3) && (((m_c - 1) % (m_d + 1)) == 0);
  endfunction

  function automatic bit any_ge(input logic [23:0] b);
    for (int i = 0; i < 6; i++)
      if (b[i*4 +: 4] >= 4'(TB_OVF_TH)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    ph = 0; m_c = 0; m_d = 0; m_f = 0;
    m_en = 0; m_stop = 0; m_under = 0; m_alarm = 0;
    m_last = '0;
    exp_q.delete();
  endtask

  task automatic drive_sfi();
    case (sfi_mode)
      0:       sfi_bus = 24'h0;
      1:       sfi_bus = 24'h111111;
      2:       sfi_bus = (m_f >= 3) ? 24'h0 : 24'h333333;
      default: sfi_bus = sfi_val;
    endcase
  endtask

  task automatic check_outputs();
    bit tk = m_tick();
    chk("busy", busy, ph != 0);
    chk("filt_clr", filt_clr, ph == 1);
    chk("filt_en", filt_en, m_en);
    if (m_en) begin
      chk("pulse_queue", exp_q.size(), 1);
      if (exp_q.size() > 0) m_last = exp_q.pop_front();
    end
    chk("st_out", st_out, m_last);
    chk("st_ready", st_if.st_ready, ph == 2 && tk && !m_stop);
    chk("underrun", underrun, m_under);
    chk("ovf_alarm", ovf_alarm, m_alarm);
  endtask

  task automatic model_edge();
    bit tk = m_tick();
    bit n_en = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_en && any_ge(sfi_bus)) m_alarm = 1;
    case (ph)
      0: begin
        m_last = '0;
        if (start) begin
          ph = 1; m_c = 1; m_under = 0; m_alarm = 0; m_stop = 0;
        end
      end
      1: begin
        m_d = int'(div_cfg); m_f = 0; ph = 2;
        if (stop) m_stop = 1;
        m_c++;
      end
      2: begin
        if (tk && m_stop) ph = 3;
        else if (tk) begin
          exp_q.push_back(st_if.st_valid ? st_if.st_in : 6'd0);
          n_en = 1;
          if (!st_if.st_valid) m_under = 1;
        end
        if (stop) m_stop = 1;
        m_c++;
      end
      default: begin
        if (tk) begin
          if (sfi_bus == 24'h0 || m_f == TB_FLUSH) ph = 0;
          else begin
            exp_q.push_back(6'd0);
            n_en = 1;
            m_f++;
          end
        end
        m_c++;
      end
    endcase
    m_en = n_en;
  endtask

  // one clock: check at negedge, advance model, return at posedge+1 for new inputs
  task automatic step();
    drive_sfi();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_cfg = '0;
    st_if.st_in = '0; st_if.st_valid = 1'b0;
    sfi_mode = 0; sfi_val = '0; sfi_bus = '0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();

    // basic run: period 4, constant vector, then stop with filter already at zero
    div_cfg = 8'd3; st_if.st_valid = 1'b1; st_if.st_in = 6'b000111;
    pulse_start();
    repeat (24) step();
    pulse_stop();
    repeat (10) step();

    // random run with drain: filter outputs fall to zero after 3 drain pulses
    div_cfg = 8'($urandom_range(0, 4));
    sfi_mode = 2;
    pulse_start();
    repeat (40) begin
      st_if.st_valid = ($urandom_range(0, 3) != 0);
      st_if.st_in    = 6'($urandom_range(0, 63));
      start          = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    pulse_stop();
    repeat (40) step();
    chk("drain_idle", busy, 1'b0);

    // start and stop together in idle: run proceeds normally
    div_cfg = 8'd2; sfi_mode = 0; st_if.st_valid = 1'b1; st_if.st_in = 6'h15;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    repeat (15) step();
    pulse_stop();
    repeat (8) step();

    // underrun: tick every cycle, two ticks without a vector
    div_cfg = 8'd0; st_if.st_in = 6'h2C;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      st_if.st_valid = !(i == 4 || i == 7);
      step();
    end
    st_if.st_valid = 1'b1;
    pulse_stop();
    repeat (6) step();
    chk("underrun_held", underrun, 1'b1);

    // alarm: nibble 2 at 0xB stays quiet, 0xC trips and holds
    div_cfg = 8'd0; sfi_mode = 3; sfi_val = 24'h000B00;
    pulse_start();
    chk("underrun_cleared", underrun, 1'b0);
    repeat (8) step();
    chk("alarm_below_th", ovf_alarm, 1'b0);
    sfi_val = 24'h000C00;
    repeat (3) step();
    sfi_val = 24'h0;
    pulse_stop();
    repeat (6) step();
    chk("alarm_held", ovf_alarm, 1'b1);

    // drain cap: filter never settles, drain stops after FLUSH_CYC pulses
    div_cfg = 8'd0; sfi_mode = 1;
    pulse_start();
    chk("alarm_cleared", ovf_alarm, 1'b0);
    repeat (6) step();
    pulse_stop();
    en_cnt = 0;
    repeat (25) begin
      if (filt_en) en_cnt++;
      step();
    end
    chk("drain_cap_pulses", en_cnt, 1 + TB_FLUSH);
    chk("drain_cap_idle", busy, 1'b0);

    // asynchronous reset in the middle of a run
    div_cfg = 8'd5; sfi_mode = 0; st_if.st_valid = 1'b1; st_if.st_in = 6'h2A;
    pulse_start();
    repeat (20) step();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_filt_en", filt_en, 1'b0);
    chk("rst_filt_clr", filt_clr, 1'b0);
    chk("rst_st_out", st_out, 6'd0);
    chk("rst_st_ready", st_if.st_ready, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ovf_alarm", ovf_alarm, 1'b0);
    model_reset();
    step();
    rst = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
